// File: rtl/tdm_channel_demux.sv
// tdm_channel_demux: reassembles a time-interleaved TDM sample stream into parallel frames.
// Optional error counters are enabled by defining TDM_DEMUX_ERRCNT_EN.
module tdm_channel_demux #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic                               in_frame_start,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                               locked,
    output logic                               frame_err,
    output logic                               overrun,
    input  logic                               err_clear
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [15:0]                        frame_err_cnt,
    output logic [15:0]                        overrun_cnt
`endif
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int LW = (NUM_CHANNELS - 1) * DATA_WIDTH;

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   slot_cnt, slot_nxt, lane_idx;
    logic [LW-1:0]   lanes;
    logic            lane_we, last, complete, ferr_ev, ovr_ev, load;

    // The last slot is never stored: it goes straight into out_data with the other lanes.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt;
        lane_we   = 1'b0;
        lane_idx  = slot_cnt;
        complete  = 1'b0;
        ferr_ev   = 1'b0;
        last      = slot_cnt == CW'(NUM_CHANNELS - 1);
        if (in_valid) begin
            if (state == HUNT) begin
                if (in_frame_start) begin
                    lane_we   = 1'b1;
                    lane_idx  = '0;
                    slot_nxt  = CW'(1);
                    state_nxt = COLLECT;
                end
            end else if (in_frame_start) begin
                ferr_ev  = slot_cnt != '0;
                lane_we  = 1'b1;
                lane_idx = '0;
                slot_nxt = CW'(1);
            end else if (slot_cnt == '0) begin
                ferr_ev   = 1'b1;
                state_nxt = HUNT;
            end else if (last) begin
                complete = 1'b1;
                slot_nxt = '0;
            end else begin
                lane_we  = 1'b1;
                slot_nxt = slot_cnt + 1'b1;
            end
        end
        load   = complete && (!out_valid || out_ready);
        ovr_ev = complete && out_valid && !out_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            slot_cnt <= '0;
        end else begin
            state    <= state_nxt;
            slot_cnt <= slot_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS - 1; k++)
                if (lane_we && lane_idx == CW'(k))
                    lanes[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= {in_data, lanes};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A new event in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_ev || (frame_err && !err_clear);
            overrun   <= ovr_ev || (overrun && !err_clear);
        end
    end

    assign locked = state == COLLECT;

`ifdef TDM_DEMUX_ERRCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_cnt <= '0;
            overrun_cnt   <= '0;
        end else if (err_clear) begin
            frame_err_cnt <= {15'd0, ferr_ev};
            overrun_cnt   <= {15'd0, ovr_ev};
        end else begin
            frame_err_cnt <= (ferr_ev && frame_err_cnt != 16'hFFFF) ? frame_err_cnt + 16'd1 : frame_err_cnt;
            overrun_cnt   <= (ovr_ev && overrun_cnt != 16'hFFFF) ? overrun_cnt + 16'd1 : overrun_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_tdm_channel_demux.sv
// tb_tdm_channel_demux: directed scenarios plus a randomized stream checked against a frame-level model.
module tb_tdm_channel_demux;
    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_frame_start = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            out_ready = 1'b0;
    logic            err_clear = 1'b0;
    logic            out_valid, locked, frame_err, overrun;
    logic [N*DW-1:0] out_data;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [15:0]     frame_err_cnt, overrun_cnt;
`endif

    tdm_channel_demux #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_frame_start(in_frame_start),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .locked(locked), .frame_err(frame_err), .overrun(overrun), .err_clear(err_clear)
`ifdef TDM_DEMUX_ERRCNT_EN
        , .frame_err_cnt(frame_err_cnt), .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Frame-level reference: position within frame, collected samples, one-deep output slot.
    bit              m_hunt;
    int              m_pos;
    logic [DW-1:0]   m_part [N];
    logic            m_valid, m_ferr, m_ovr;
    logic [N*DW-1:0] m_data;
    int              m_fcnt, m_ocnt;

    task automatic model_reset();
        m_hunt = 1; m_pos = 0; m_valid = 0; m_data = '0; m_ferr = 0; m_ovr = 0;
        m_fcnt = 0; m_ocnt = 0;
        foreach (m_part[k]) m_part[k] = '0;
    endtask

    task automatic cycle(input logic v, input logic fs, input logic [DW-1:0] d, input logic rdy, input logic clr);
        bit fe = 0, done = 0, ov = 0;
        logic [N*DW-1:0] fr;
        in_valid = v; in_frame_start = fs; in_data = d; out_ready = rdy; err_clear = clr;
        @(posedge clk);
        if (v) begin
            if (fs) begin
                fe = !m_hunt && m_pos != 0;
                m_hunt = 0; m_part[0] = d; m_pos = 1;
            end else if (!m_hunt) begin
                if (m_pos == 0) begin
                    fe = 1; m_hunt = 1;
                end else begin
                    m_part[m_pos] = d; m_pos++;
                    if (m_pos == N) begin done = 1; m_pos = 0; end
                end
            end
        end
        if (done) begin
            for (int k = 0; k < N; k++) fr[k*DW +: DW] = m_part[k];
            if (!m_valid || rdy) begin m_data = fr; m_valid = 1; end
            else ov = 1;
        end else if (m_valid && rdy) m_valid = 0;
        m_ferr = fe || (m_ferr && !clr);
        m_ovr  = ov || (m_ovr && !clr);
        m_fcnt = clr ? int'(fe) : (fe && m_fcnt < 65535) ? m_fcnt + 1 : m_fcnt;
        m_ocnt = clr ? int'(ov) : (ov && m_ocnt < 65535) ? m_ocnt + 1 : m_ocnt;
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d [N], input logic rdy);
        for (int k = 0; k < N; k++) cycle(1, k == 0, d[k], rdy, 0);
    endtask

    task automatic test_reset();
        reset = 0;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        model_reset();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %b exp 0", locked); end
        tests++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b exp 00", frame_err, overrun); end
        reset = 1;
    endtask

    task automatic test_basic();
        cycle(1, 1, 32'h10, 1, 0);
        cycle(1, 0, 32'h11, 1, 0);
        cycle(1, 0, 32'h12, 1, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
        cycle(1, 0, 32'h13, 1, 0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        tests++; if (out_data !== 128'h00000013_00000012_00000011_00000010) begin fails++; $display("FAIL basic_data got %h exp %h", out_data, 128'h00000013_00000012_00000011_00000010); end
        tests++; if (frame_err !== 1'b0 || overrun !== 1'b0 || locked !== 1'b1) begin fails++; $display("FAIL basic_flags got err=%b ovr=%b lock=%b exp 0 0 1", frame_err, overrun, locked); end
        cycle(0, 0, 0, 1, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_hunt();
        logic [DW-1:0] a [N];
        logic [N*DW-1:0] exp_f;
        test_reset();
        for (int k = 0; k < N; k++) begin
            cycle(1, 0, $urandom, 1, 0);
            tests++; if (locked !== 1'b0) begin fails++; $display("FAIL hunt_locked beat %0d got %b exp 0", k, locked); end
        end
        for (int k = 0; k < N; k++) begin a[k] = $urandom; exp_f[k*DW +: DW] = a[k]; end
        send_frame(a, 1);
        tests++; if (out_valid !== 1'b1 || out_data !== exp_f) begin fails++; $display("FAIL hunt_frame got %b %h exp 1 %h", out_valid, out_data, exp_f); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL hunt_frame_err got %b exp 0", frame_err); end
    endtask

    task automatic test_early_start();
        cycle(1, 1, 32'h30, 1, 0);
        cycle(1, 0, 32'h31, 1, 0);
        cycle(1, 1, 32'h20, 1, 0);
        tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL early_frame_err got %b exp 1", frame_err); end
        tests++; if (out_valid !== 1'b0 || locked !== 1'b1) begin fails++; $display("FAIL early_state got valid=%b lock=%b exp 0 1", out_valid, locked); end
        cycle(1, 0, 32'h21, 1, 0);
        cycle(1, 0, 32'h22, 1, 0);
        cycle(1, 0, 32'h23, 1, 0);
        tests++; if (out_valid !== 1'b1 || out_data !== 128'h00000023_00000022_00000021_00000020) begin fails++; $display("FAIL early_next_frame got %b %h exp 1 %h", out_valid, out_data, 128'h00000023_00000022_00000021_00000020); end
        cycle(0, 0, 0, 1, 1);
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL early_clear got %b exp 0", frame_err); end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] f1 [N], f2 [N];
        logic [N*DW-1:0] e1;
        for (int k = 0; k < N; k++) begin f1[k] = $urandom; f2[k] = $urandom; e1[k*DW +: DW] = f1[k]; end
        send_frame(f1, 0);
        send_frame(f2, 0);
        tests++; if (out_valid !== 1'b1 || out_data !== e1) begin fails++; $display("FAIL ovr_hold got %b %h exp 1 %h", out_valid, out_data, e1); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        cycle(0, 0, 0, 1, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovr_accept got %b exp 0", out_valid); end
        cycle(0, 0, 0, 0, 1);
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] g1 [N], g2 [N];
        logic [N*DW-1:0] e2;
        for (int k = 0; k < N; k++) begin g1[k] = $urandom; g2[k] = $urandom; e2[k*DW +: DW] = g2[k]; end
        send_frame(g1, 0);
        for (int k = 0; k < N; k++) cycle(1, k == 0, g2[k], k == N - 1, 0);
        tests++; if (out_valid !== 1'b1 || out_data !== e2) begin fails++; $display("FAIL b2b_frame got %b %h exp 1 %h", out_valid, out_data, e2); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
        cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] p [N], q [N];
        logic [N*DW-1:0] eq;
        for (int k = 0; k < N; k++) begin p[k] = $urandom; q[k] = $urandom; eq[k*DW +: DW] = q[k]; end
        send_frame(p, 0);
        cycle(1, 1, $urandom, 0, 0);
        cycle(1, 0, $urandom, 0, 0);
        reset = 0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_data !== '0 || locked !== 1'b0) begin fails++; $display("FAIL midrst_outputs got %b %h %b exp 0 0 0", out_valid, out_data, locked); end
        cycle(0, 0, 0, 0, 0);
        model_reset();
        reset = 1;
        send_frame(q, 1);
        tests++; if (out_valid !== 1'b1 || out_data !== eq) begin fails++; $display("FAIL midrst_frame got %b %h exp 1 %h", out_valid, out_data, eq); end
        cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        int pos = 0;
        logic v, fs;
        for (int i = 0; i < 3000; i++) begin
            v  = $urandom_range(0, 3) != 0;
            fs = (pos == 0) ^ ($urandom_range(0, 15) == 0);
            if (v) pos = (pos + 1) % N;
            cycle(v, fs, $urandom, $urandom_range(0, 1), $urandom_range(0, 31) == 0);
            tests++;
            if (out_valid !== m_valid || (m_valid && out_data !== m_data) || locked !== !m_hunt || frame_err !== m_ferr || overrun !== m_ovr) begin
                fails++;
                $display("FAIL rnd cyc %0d got v=%b d=%h l=%b e=%b o=%b exp v=%b d=%h l=%b e=%b o=%b", i, out_valid, out_data, locked, frame_err, overrun, m_valid, m_data, !m_hunt, m_ferr, m_ovr);
            end
`ifdef TDM_DEMUX_ERRCNT_EN
            tests++;
            if (frame_err_cnt !== 16'(m_fcnt) || overrun_cnt !== 16'(m_ocnt)) begin
                fails++;
                $display("FAIL rnd_cnt cyc %0d got %0d %0d exp %0d %0d", i, frame_err_cnt, overrun_cnt, m_fcnt, m_ocnt);
            end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_hunt();
        test_early_start();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
